// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for an 8-entry FIFO. Pops a commanded
// number of words, absorbs the 1-cycle FIFO read latency in a 2-entry output
// buffer and hands words downstream on a valid/ready handshake.
module fifo_reader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              abort,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_data_count,
  output logic              fifo_re,
  input  logic              fifo_rd_ack,
  input  logic              fifo_rd_err,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  words_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state, state_nx;
  logic [CNT_W-1:0]  remaining, rem_nx, len_c;
  logic              pend;        // read issued last cycle; response due now
  logic              abort_q;
  logic [DATA_W-1:0] buf_q [2];
  logic              head, tail;
  logic [1:0]        occ, occ_nx;
  logic [2:0]        load;
  logic              ack_ok, push, pop, issue;

  // Occupancy is status only; reads are throttled by fifo_empty.
  logic unused;
  assign unused = ^fifo_data_count;

  assign len_c     = (len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : len;
  assign ack_ok    = pend & fifo_rd_ack & ~fifo_rd_err;
  assign out_valid = (occ != 2'd0);
  assign out_data  = buf_q[head];
  assign pop       = out_valid & out_ready;
  assign push      = ack_ok & ((occ != 2'd2) | pop);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign aborted   = done & abort_q;

  // Issue decision for next cycle's fifo_re. 'load' is what the buffer will
  // hold once every read already issued has landed, assuming no further pops.
  // A consumer that is accepting now earns one extra read in flight so the
  // stream runs at one word per cycle.
  always_comb begin
    rem_nx = remaining;
    if (ack_ok && remaining != '0) rem_nx = remaining - CNT_W'(1);
    occ_nx = occ + {1'b0, push} - {1'b0, pop};
    load   = {1'b0, occ} + {2'b0, ack_ok} + {2'b0, fifo_re} - {2'b0, pop};
    issue  = (state == S_RUN) && !abort && !fifo_empty &&
             (rem_nx > {{(CNT_W-1){1'b0}}, fifo_re}) &&
             ((load < 3'd2) || (out_ready && load < 3'd3));
  end

  // Command sequencing: IDLE -> RUN/DONE, RUN -> DRAIN, DRAIN -> DONE -> IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (len_c == '0) ? S_DONE : S_RUN;
      S_RUN:   if (abort || rem_nx == '0) state_nx = S_DRAIN;
      S_DRAIN: if (!fifo_re && occ_nx == 2'd0) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, remaining word count and abort flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      abort_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE) begin
        if (start) begin
          remaining <= len_c;
          abort_q   <= 1'b0;
        end
      end else begin
        remaining <= rem_nx;
        if (state == S_RUN && abort) abort_q <= 1'b1;
      end
    end
  end

  // Registered read enable and its one-cycle-late response tracker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_re <= 1'b0;
      pend    <= 1'b0;
    end else begin
      fifo_re <= issue;
      pend    <= fifo_re;
    end
  end

  // Two-entry output buffer in FIFO order; push and pop may coincide when full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      occ      <= 2'd0;
    end else begin
      if (push) begin
        buf_q[tail] <= fifo_dout;
        tail        <= ~tail;
      end
      if (pop) head <= ~head;
      occ <= occ_nx;
    end
  end

  // Delivered-word counter: cleared on start, saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_done <= '0;
    end else if (state == S_IDLE && start) begin
      words_done <= '0;
    end else if (pop && words_done != '1) begin
      words_done <= words_done + CNT_W'(1);
    end
  end

endmodule
